// File: rtl/search_pkg.sv
// Shared types and default widths for the search_scan key-search controller.
package search_pkg;

  localparam int A_DEF = 8;
  localparam int D_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/search.sv
// Equality comparator: q5 is high when enabled and both operands are equal.
module search
  import search_pkg::*;
#(
  parameter int W = D_DEF
) (
  input  logic [W-1:0] q1,
  input  logic [W-1:0] q2,
  input  logic         enble,
  output logic         q5
);

  assign q5 = enble && (q1 == q2);

endmodule

// File: rtl/search_scan.sv
// Sequential key search over a synchronous-read table; reports the first matching address.
// Optional build macro SEARCH_MASK_EN adds a key_mask input for masked compares.
module search_scan
  import search_pkg::*;
#(
  parameter int A = A_DEF,
  parameter int D = D_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [D-1:0] key,
`ifdef SEARCH_MASK_EN
  input  logic [D-1:0] key_mask,
`endif
  input  logic [A-1:0] last_addr,
  output logic         mem_rd,
  output logic [A-1:0] mem_addr,
  input  logic [D-1:0] mem_q,
  output logic         busy,
  output logic         done,
  output logic         hit,
  output logic [A-1:0] hit_addr,
  output state_e       state_dbg
);

  // Handshake: start is taken on a cycle where busy is low (IDLE or DONE);
  // a start seen while busy is high is dropped, nothing is queued.

  state_e         state_q, state_d;
  logic [D-1:0]   key_q, key_d;
  logic [A-1:0]   last_q, last_d;
  logic           mem_rd_q, mem_rd_d;
  logic [A-1:0]   mem_addr_q, mem_addr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           hit_q, hit_d;
  logic [A-1:0]   hit_addr_q, hit_addr_d;
  logic           rd_vld_q;
  logic [A-1:0]   rd_addr_q;
  logic           match;
  logic [D-1:0]   mem_m, key_m;

`ifdef SEARCH_MASK_EN
  logic [D-1:0]   mask_q, mask_d;
  assign mem_m = mem_q & mask_q;
  assign key_m = key_q & mask_q;
`else
  assign mem_m = mem_q;
  assign key_m = key_q;
`endif

  search #(.W(D)) u_cmp (
    .q1    (mem_m),
    .q2    (key_m),
    .enble (rd_vld_q),
    .q5    (match)
  );

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    last_d     = last_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    hit_d      = hit_q;
    hit_addr_d = hit_addr_q;
`ifdef SEARCH_MASK_EN
    mask_d     = mask_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d    = RUN;
          key_d      = key;
          last_d     = last_addr;
          mem_rd_d   = 1'b1;
          mem_addr_d = '0;
          hit_d      = 1'b0;
          hit_addr_d = '0;
`ifdef SEARCH_MASK_EN
          mask_d     = key_mask;
`endif
        end
      end
      RUN: begin
        if (match) begin
          // The read already issued past the hit is left to return unused.
          state_d    = DONE;
          done_d     = 1'b1;
          hit_d      = 1'b1;
          hit_addr_d = rd_addr_q;
        end else if (mem_addr_q == last_q) begin
          state_d = DRAIN;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d    = DONE;
        done_d     = 1'b1;
        hit_d      = match;
        hit_addr_d = match ? rd_addr_q : '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= '0;
      last_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      hit_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_addr_q  <= '0;
`ifdef SEARCH_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      last_q     <= last_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      hit_addr_q <= hit_addr_d;
      rd_vld_q   <= mem_rd_q;
      rd_addr_q  <= mem_addr_q;
`ifdef SEARCH_MASK_EN
      mask_q     <= mask_d;
`endif
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit       = hit_q;
  assign hit_addr  = hit_addr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_search_scan.sv
// Self-checking bench for search_scan: directed scans plus randomized scans vs a table-walk model.
module tb_search_scan;
  import search_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] key;
  logic [7:0] key_mask;
  logic [7:0] last_addr;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_q;
  logic       busy, done, hit;
  logic [7:0] hit_addr;
  state_e     state_dbg;

  logic [7:0] tbl [256];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  search_scan dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
`ifdef SEARCH_MASK_EN
    .key_mask  (key_mask),
`endif
    .last_addr (last_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_q     (mem_q),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hit_addr  (hit_addr),
    .state_dbg (state_dbg)
  );

  // Synchronous-read table RAM model
  always @(posedge clk) if (mem_rd) mem_q <= tbl[mem_addr];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or after idle gap).
  task automatic run_scan(input logic [7:0] k, input logic [7:0] m, input logic [7:0] l,
                          input bit glitch, input int gap);
    int  found_at, exp_cyc, exp_reads, exp_hit, exp_haddr;
    int  reads, seq_err, busy_err, done_c;
    logic [7:0] mm;
`ifdef SEARCH_MASK_EN
    mm = m;
`else
    mm = 8'hFF;
`endif
    found_at = -1;
    for (int i = 0; i <= int'(l); i++) begin
      if ((tbl[i] & mm) == (k & mm)) begin
        found_at = i;
        break;
      end
    end
    if (found_at >= 0) begin
      exp_cyc   = found_at + 3;
      exp_reads = (found_at < int'(l)) ? found_at + 2 : found_at + 1;
      exp_hit   = 1;
      exp_haddr = found_at;
    end else begin
      exp_cyc   = int'(l) + 3;
      exp_reads = int'(l) + 1;
      exp_hit   = 0;
      exp_haddr = 0;
    end

    start = 1'b1; key = k; key_mask = m; last_addr = l;
    @(posedge clk);
    #1 start = 1'b0;
    reads = 0; seq_err = 0; busy_err = 0; done_c = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (glitch && exp_cyc > 4 && c == 3) begin
        start = 1'b1; key = ~k; key_mask = ~m; last_addr = 8'h00;
      end
      if (glitch && exp_cyc > 4 && c == 4) begin
        start = 1'b0; key = k; key_mask = m; last_addr = l;
      end
      if (c == 1) chk("hit_clr", int'(hit), 0);
      if (mem_rd) begin
        if (mem_addr !== reads[7:0]) seq_err++;
        reads++;
      end
      if (busy !== !done) busy_err++;
      if (done) begin
        done_c = c;
        break;
      end
    end
    if (done_c < 0) chk("timeout", 1, 0);
    chk("done_cyc", done_c, exp_cyc);
    chk("hit", int'(hit), exp_hit);
    chk("hit_addr", int'(hit_addr), exp_haddr);
    chk("nreads", reads, exp_reads);
    chk("addr_seq_err", seq_err, 0);
    chk("busy_err", busy_err, 0);
    if (gap > 0) begin
      repeat (gap) @(negedge clk);
      chk("hit_hold", int'(hit), exp_hit);
      chk("haddr_hold", int'(hit_addr), exp_haddr);
    end
  endtask

  initial begin
    int ndone;
    logic [7:0] rk, rm, rl;
    rst = 1'b1; start = 1'b0; key = '0; key_mask = 8'hFF; last_addr = '0;
    for (int i = 0; i < 256; i++) tbl[i] = i[7:0];
    repeat (3) @(negedge clk);
    chk("rst_outs", int'({mem_rd, mem_addr, busy, done, hit, hit_addr}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Ascending table, key present
    run_scan(8'h05, 8'hFF, 8'h0F, 1'b0, 2);
    // Duplicate key: lowest address wins
    tbl[5] = 8'hAA; tbl[9] = 8'hAA;
    run_scan(8'hAA, 8'hFF, 8'h0F, 1'b0, 0);
    for (int i = 0; i < 256; i++) tbl[i] = i[7:0];
    // Absent key, short range
    run_scan(8'hFF, 8'hFF, 8'h03, 1'b0, 1);
    // Full depth miss: counter must stop at 0xFF
    for (int i = 0; i < 256; i++) tbl[i] = i[7:0] & 8'h7F;
    run_scan(8'h80, 8'hFF, 8'hFF, 1'b0, 0);
    // Match on the final address of the range
    run_scan(8'h0F, 8'hFF, 8'h0F, 1'b0, 0);
    // start while busy must be ignored
    run_scan(8'h0C, 8'hFF, 8'h0F, 1'b1, 1);

    // Reset at cycle 4 of a scan aborts it
    start = 1'b1; key = 8'hFF; key_mask = 8'hFF; last_addr = 8'h0F;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", int'({mem_rd, mem_addr, busy, done, hit, hit_addr}), 0);
    rst = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_no_done", ndone, 0);

`ifdef SEARCH_MASK_EN
    for (int i = 0; i < 256; i++) tbl[i] = i[7:0];
    tbl[2] = 8'h31;
    run_scan(8'h3C, 8'hF0, 8'h0F, 1'b0, 0);
    run_scan(8'h77, 8'h00, 8'h0F, 1'b0, 0);
`endif

    // Randomized scans, many of them back-to-back
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom_range(0, 255));
      rl = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) rk = tbl[$urandom_range(0, int'(rl))];
      else rk = 8'($urandom_range(0, 255));
`ifdef SEARCH_MASK_EN
      rm = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
`else
      rm = 8'hFF;
`endif
      run_scan(rk, rm, rl, $urandom_range(0, 3) == 0, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/search_scan.md
# search_scan

Sequential key-search controller: on `start`, walks a synchronous read memory from address 0 up to `last_addr`, compares each returned word with a latched key, and reports the first matching address or a miss. It is the initiator that drives the team's `search` equality comparator. It sits between the control logic that issues lookups and the table RAM, and issues one read per cycle (pipelined).

## Interface
- `A`, 8, address width (table depth up to 2^A)
- `D`, 8, data/key width

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a scan; accepted only when `busy`=0
- `key`  in  D  search key, sampled with accepted `start`
- `last_addr`  in  A  highest address to scan (inclusive), sampled with accepted `start`
- `mem_rd`  out  1  read strobe to table RAM
- `mem_addr`  out  A  read address
- `mem_q`  in  D  read data, valid exactly 1 cycle after `mem_rd`
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle completion pulse
- `hit`  out  1  result of last scan: match found
- `hit_addr`  out  A  lowest matching address; 0 on miss

## Operation
- States: IDLE, RUN (issuing reads), DRAIN (last read in flight), DONE (one cycle).
- IDLE/DONE + `start`=1: latch `key`, `last_addr`; clear address counter `cnt`; go RUN.
- RUN: `mem_rd`=1, `mem_addr`=`cnt`; if `cnt`==`last_addr` go DRAIN, else `cnt`+1. Counter never wraps (`last_addr`=2^A-1 stops at 2^A-1).
- Read-valid pipeline: `rd_vld`/`rd_addr` delay `mem_rd`/`mem_addr` by one cycle.
- Compare every cycle `rd_vld`=1: match = (`mem_q`==`key_q`). On match (RUN or DRAIN): register `hit`=1, `hit_addr`=`rd_addr`, go DONE. At most one read beyond the hit address is issued; its data is discarded.
- DRAIN without match: `hit`=0, `hit_addr`=0, go DONE.
- DONE: `done`=1 for one cycle, then IDLE (or RUN if `start`=1).
- `start` while `busy`=1 is ignored; no queuing.
- `hit`/`hit_addr` hold until the next DONE; they are cleared on accepted `start`.

## Timing
- Reset values: `mem_rd`=0, `mem_addr`=0, `busy`=0, `done`=0, `hit`=0, `hit_addr`=0, state IDLE.
- Reset mid-scan aborts immediately. No `done` is produced and outputs take their reset values next cycle.
- All outputs are registered.
- `start` accepted in cycle 0. First read (address 0) issues in cycle 1. Address n issues in cycle n+1 and is compared in cycle n+2.
- Match at address k: `done`=1, `hit`=1 in cycle k+3.
- Miss: `done`=1, `hit`=0 in cycle `last_addr`+3.
- `busy`=1 in RUN/DRAIN only. It is 0 in the `done` cycle, so back-to-back `start` in the DONE cycle is accepted.

## Configuration
- `SEARCH_MASK_EN` defined: adds input `key_mask` (D bits), latched with `start`. Match = ((`mem_q` & `mask_q`) == (`key_q` & `mask_q`)). A mask of all-zero matches address 0.
- Not defined: port absent; full-width equality.

## Structure
- Package `search_pkg`: state enum (IDLE, RUN, DRAIN, DONE), default `A`/`D` localparams.
- Sub-module: instantiate the existing `search` comparator. Connections: `q1`=masked `mem_q`, `q2`=masked `key_q`, `enble`=`rd_vld`, `q5`=match.

## Test plan
- Table[i]=i, key=0x05, last_addr=0x0F, start at cycle 0 -> reads 0..6 issued, `done`/`hit`=1 at cycle 8, `hit_addr`=0x05.
- Table[5]=Table[9]=0xAA, key=0xAA -> `hit_addr`=0x05, not 0x09.
- key=0xFF absent, last_addr=0x03 -> reads 0..3 only, `done`=1 at cycle 6, `hit`=0, `hit_addr`=0.
- last_addr=0xFF, no match -> 256 reads, `mem_addr` never wraps to 0, `done` at cycle 258.
- `start` pulsed while `busy` -> ignored, key unchanged. `rst` at cycle 4 of a scan -> no `done`, all outputs 0 next cycle.
- With `SEARCH_MASK_EN`: key=0x3C, mask=0xF0, Table[2]=0x31 -> `hit`=1, `hit_addr`=0x02.
